// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer and the rest of the 8-bit bus CPU.
// Carries the opcode/flag inputs, every control strobe and the debug step.
// Optional single-step pins exist only when CONTROL_SEQUENCER_SINGLE_STEP_EN
// is defined.
interface control_sequencer_if #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
);
  logic [OPCODE_WIDTH-1:0] i_OPCODE;
  logic                    i_CARRY;
  logic                    i_ZERO;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  logic                    i_STEP_MODE;
  logic                    i_STEP;
`endif
  logic                    o_PC_OUT;
  logic                    o_PC_COUNT_ENABLE;
  logic                    o_PC_JUMP;
  logic                    o_MAR_IN;
  logic                    o_RAM_OUT;
  logic                    o_RAM_IN;
  logic                    o_IR_IN;
  logic                    o_IR_OUT;
  logic                    o_A_IN;
  logic                    o_A_OUT;
  logic                    o_B_IN;
  logic                    o_ALU_OUT;
  logic                    o_ALU_SUB;
  logic                    o_FLAGS_IN;
  logic                    o_OUT_IN;
  logic                    o_HALTED;
  logic [STEP_WIDTH-1:0]   o_STEP;

  // Sequencer side: consumes opcode/flags, drives the strobes.
  modport master (
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    input  i_STEP_MODE, i_STEP,
`endif
    input  i_OPCODE, i_CARRY, i_ZERO,
    output o_PC_OUT, o_PC_COUNT_ENABLE, o_PC_JUMP, o_MAR_IN, o_RAM_OUT,
           o_RAM_IN, o_IR_IN, o_IR_OUT, o_A_IN, o_A_OUT, o_B_IN, o_ALU_OUT,
           o_ALU_SUB, o_FLAGS_IN, o_OUT_IN, o_HALTED, o_STEP
  );

  // Datapath side: supplies opcode/flags, obeys the strobes.
  modport slave (
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    output i_STEP_MODE, i_STEP,
`endif
    output i_OPCODE, i_CARRY, i_ZERO,
    input  o_PC_OUT, o_PC_COUNT_ENABLE, o_PC_JUMP, o_MAR_IN, o_RAM_OUT,
           o_RAM_IN, o_IR_IN, o_IR_OUT, o_A_IN, o_A_OUT, o_B_IN, o_ALU_OUT,
           o_ALU_SUB, o_FLAGS_IN, o_OUT_IN, o_HALTED, o_STEP
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: 2-step fetch plus 0..3 execute steps per
// instruction, one microstep per clock. Strobes are a combinational decode
// of (step, opcode, flags), forced low during reset and while halted.
// Optional feature macro: CONTROL_SEQUENCER_SINGLE_STEP_EN (adds manual
// single-step mode through i_STEP_MODE / i_STEP).
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                 i_CLOCK,
  input  logic                 i_CLEAR_n,
  control_sequencer_if.master  bus
);

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

  localparam logic [STEP_WIDTH-1:0] T0 = STEP_WIDTH'(0);
  localparam logic [STEP_WIDTH-1:0] T1 = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] T2 = STEP_WIDTH'(2);
  localparam logic [STEP_WIDTH-1:0] T3 = STEP_WIDTH'(3);
  localparam logic [STEP_WIDTH-1:0] T4 = STEP_WIDTH'(4);

  typedef struct packed {
    logic pc_out;
    logic pc_count_enable;
    logic pc_jump;
    logic mar_in;
    logic ram_out;
    logic ram_in;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
    logic alu_sub;
    logic flags_in;
    logic out_in;
  } ctrl_t;

  logic [STEP_WIDTH-1:0] step;
  logic [STEP_WIDTH-1:0] last_step;
  logic [STEP_WIDTH-1:0] step_next;
  logic                  halted;
  logic                  advance;
  ctrl_t                 decode;
  ctrl_t                 ctrl;

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  logic step_d;

  // Delayed copy of i_STEP for rising-edge detection of the manual pulse.
  always_ff @(posedge i_CLOCK) begin
    if (!i_CLEAR_n) step_d <= 1'b0;
    else            step_d <= bus.i_STEP;
  end

  // In step mode only a fresh i_STEP rising edge lets a microstep happen.
  assign advance = bus.i_STEP_MODE ? (bus.i_STEP & ~step_d) : 1'b1;
`else
  assign advance = 1'b1;
`endif

  // Microcode ROM: strobes for the current step plus the instruction's last step.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    decode    = '0;
    last_step = T1;
    case (bus.i_OPCODE)
      OP_LDA, OP_STA:                                 last_step = T3;
      OP_ADD, OP_SUB:                                 last_step = T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   last_step = T2;
      default:                                        last_step = T1;
    endcase
    case (step)
      T0: begin
        decode.pc_out = 1'b1;
        decode.mar_in = 1'b1;
      end
      T1: begin
        decode.ram_out         = 1'b1;
        decode.ir_in           = 1'b1;
        decode.pc_count_enable = 1'b1;
      end
      T2: begin
        case (bus.i_OPCODE)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            decode.ir_out = 1'b1;
            decode.mar_in = 1'b1;
          end
          OP_LDI: begin
            decode.ir_out = 1'b1;
            decode.a_in   = 1'b1;
          end
          OP_JMP: begin
            decode.ir_out  = 1'b1;
            decode.pc_jump = 1'b1;
          end
          OP_JC: begin
            decode.ir_out  = bus.i_CARRY;
            decode.pc_jump = bus.i_CARRY;
          end
          OP_JZ: begin
            decode.ir_out  = bus.i_ZERO;
            decode.pc_jump = bus.i_ZERO;
          end
          OP_OUT: begin
            decode.a_out  = 1'b1;
            decode.out_in = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        case (bus.i_OPCODE)
          OP_LDA: begin
            decode.ram_out = 1'b1;
            decode.a_in    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            decode.ram_out = 1'b1;
            decode.b_in    = 1'b1;
          end
          OP_STA: begin
            decode.a_out  = 1'b1;
            decode.ram_in = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (bus.i_OPCODE == OP_ADD || bus.i_OPCODE == OP_SUB) begin
          decode.alu_out  = 1'b1;
          decode.a_in     = 1'b1;
          decode.flags_in = 1'b1;
          decode.alu_sub  = (bus.i_OPCODE == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // Strobes are silenced in reset, while halted, and between manual pulses.
  assign ctrl = (i_CLEAR_n && !halted && advance) ? decode : '0;

  // Back to T0 after the instruction's last step; out-of-range steps also wrap.
  assign step_next = (step > T4 || step >= last_step) ? T0 : step + T1;

  // Step counter and halt flag.
  always_ff @(posedge i_CLOCK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!i_CLEAR_n) begin
      step   <= T0;
      halted <= 1'b0;
    end else if (!halted && advance) begin
      if (step == T2 && bus.i_OPCODE == OP_HLT) halted <= 1'b1;
      else                                      step   <= step_next;
    end
  end

  assign bus.o_PC_OUT          = ctrl.pc_out;
  assign bus.o_PC_COUNT_ENABLE = ctrl.pc_count_enable;
  assign bus.o_PC_JUMP         = ctrl.pc_jump;
  assign bus.o_MAR_IN          = ctrl.mar_in;
  assign bus.o_RAM_OUT         = ctrl.ram_out;
  assign bus.o_RAM_IN          = ctrl.ram_in;
  assign bus.o_IR_IN           = ctrl.ir_in;
  assign bus.o_IR_OUT          = ctrl.ir_out;
  assign bus.o_A_IN            = ctrl.a_in;
  assign bus.o_A_OUT           = ctrl.a_out;
  assign bus.o_B_IN            = ctrl.b_in;
  assign bus.o_ALU_OUT         = ctrl.alu_out;
  assign bus.o_ALU_SUB         = ctrl.alu_sub;
  assign bus.o_FLAGS_IN        = ctrl.flags_in;
  assign bus.o_OUT_IN          = ctrl.out_in;
  assign bus.o_HALTED          = halted;
  assign bus.o_STEP            = step;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. Expected strobe sequences come
// from an instruction table (fetch + per-opcode execute list). Single-step
// checks are included when CONTROL_SEQUENCER_SINGLE_STEP_EN is defined.
module tb_control_sequencer;

  localparam int OW = 4;
  localparam int SW = 3;

  typedef logic [14:0] mask_t;
  localparam mask_t M_PC_OUT   = 15'h0001;
  localparam mask_t M_PC_CE    = 15'h0002;
  localparam mask_t M_PC_JUMP  = 15'h0004;
  localparam mask_t M_MAR_IN   = 15'h0008;
  localparam mask_t M_RAM_OUT  = 15'h0010;
  localparam mask_t M_RAM_IN   = 15'h0020;
  localparam mask_t M_IR_IN    = 15'h0040;
  localparam mask_t M_IR_OUT   = 15'h0080;
  localparam mask_t M_A_IN     = 15'h0100;
  localparam mask_t M_A_OUT    = 15'h0200;
  localparam mask_t M_B_IN     = 15'h0400;
  localparam mask_t M_ALU_OUT  = 15'h0800;
  localparam mask_t M_ALU_SUB  = 15'h1000;
  localparam mask_t M_FLAGS_IN = 15'h2000;
  localparam mask_t M_OUT_IN   = 15'h4000;
  localparam mask_t M_DRIVERS  = M_PC_OUT | M_RAM_OUT | M_IR_OUT | M_A_OUT | M_ALU_OUT;
  localparam mask_t FETCH0     = M_PC_OUT | M_MAR_IN;
  localparam mask_t FETCH1     = M_RAM_OUT | M_IR_IN | M_PC_CE;

  logic clk = 1'b0;
  logic clear_n;
  int   n_cmp = 0;
  int   n_err = 0;

  mask_t          exp_q[$];
  mask_t          rec_m[$];
  logic [SW-1:0]  rec_s[$];
  logic           rec_h[$];

  control_sequencer_if #(.OPCODE_WIDTH(OW), .STEP_WIDTH(SW)) bus ();

  control_sequencer #(.OPCODE_WIDTH(OW), .STEP_WIDTH(SW)) dut (
    .i_CLOCK   (clk),
    .i_CLEAR_n (clear_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic mask_t obs();
    return {bus.o_OUT_IN, bus.o_FLAGS_IN, bus.o_ALU_SUB, bus.o_ALU_OUT, bus.o_B_IN,
            bus.o_A_OUT, bus.o_A_IN, bus.o_IR_OUT, bus.o_IR_IN, bus.o_RAM_IN,
            bus.o_RAM_OUT, bus.o_MAR_IN, bus.o_PC_JUMP, bus.o_PC_COUNT_ENABLE,
            bus.o_PC_OUT};
  endfunction

  // Reference model: the full microstep list of one instruction.
  task automatic build_seq(input logic [OW-1:0] op, input logic c, input logic z);
    exp_q = {};
    exp_q.push_back(FETCH0);
    exp_q.push_back(FETCH1);
    case (op)
      4'h1: begin exp_q.push_back(M_IR_OUT | M_MAR_IN); exp_q.push_back(M_RAM_OUT | M_A_IN); end
      4'h2, 4'h3: begin
        exp_q.push_back(M_IR_OUT | M_MAR_IN);
        exp_q.push_back(M_RAM_OUT | M_B_IN);
        exp_q.push_back(M_ALU_OUT | M_A_IN | M_FLAGS_IN | ((op == 4'h3) ? M_ALU_SUB : '0));
      end
      4'h4: begin exp_q.push_back(M_IR_OUT | M_MAR_IN); exp_q.push_back(M_A_OUT | M_RAM_IN); end
      4'h5: exp_q.push_back(M_IR_OUT | M_A_IN);
      4'h6: exp_q.push_back(M_IR_OUT | M_PC_JUMP);
      4'h7: exp_q.push_back(c ? (M_IR_OUT | M_PC_JUMP) : '0);
      4'h8: exp_q.push_back(z ? (M_IR_OUT | M_PC_JUMP) : '0);
      4'hE: exp_q.push_back(M_A_OUT | M_OUT_IN);
      4'hF: exp_q.push_back('0);
      default: ;
    endcase
  endtask

  // Holds an opcode for n cycles and records what the sequencer did.
  // Flags take the given values in the third cycle and are random elsewhere.
  task automatic play(input logic [OW-1:0] op, input logic c, input logic z, input int n);
    rec_m = {}; rec_s = {}; rec_h = {};
    for (int i = 0; i < n; i++) begin
      bus.i_OPCODE = op;
      bus.i_CARRY  = (i == 2) ? c : 1'($urandom);
      bus.i_ZERO   = (i == 2) ? z : 1'($urandom);
      @(negedge clk);
      rec_m.push_back(obs());
      rec_s.push_back(bus.o_STEP);
      rec_h.push_back(bus.o_HALTED);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    bus.i_OPCODE = 4'h2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs() !== '0 || bus.o_STEP !== 3'd0 || bus.o_HALTED !== 1'b0) begin
      n_err++;
      $display("FAIL reset: strobes=%h step=%0d halted=%b, required 0000/0/0", obs(), bus.o_STEP, bus.o_HALTED);
    end
    @(posedge clk); #1;
    clear_n = 1'b1;
    n_cmp++;
    if (bus.o_STEP !== 3'd0) begin
      n_err++;
      $display("FAIL reset_release: step=%0d, required 0", bus.o_STEP);
    end
  endtask

  task automatic test_ldi();
    build_seq(4'h5, 1'b0, 1'b0);
    play(4'h5, 1'b0, 1'b0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (rec_m[i] !== exp_q[i] || rec_s[i] !== SW'(i) || rec_h[i] !== 1'b0) begin
        n_err++;
        $display("FAIL ldi T%0d: strobes=%h step=%0d halted=%b, required %h/%0d/0", i, rec_m[i], rec_s[i], rec_h[i], exp_q[i], i);
      end
    end
    n_cmp++;
    if (bus.o_STEP !== 3'd0) begin
      n_err++;
      $display("FAIL ldi_wrap: step=%0d, required 0", bus.o_STEP);
    end
  endtask

  task automatic test_add_sub();
    for (int k = 0; k < 2; k++) begin
      logic [OW-1:0] op;
      op = (k == 0) ? 4'h2 : 4'h3;
      build_seq(op, 1'b0, 1'b0);
      play(op, 1'($urandom), 1'($urandom), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (rec_m[i] !== exp_q[i] || rec_s[i] !== SW'(i)) begin
          n_err++;
          $display("FAIL add_sub op=%h T%0d: strobes=%h step=%0d, required %h/%0d", op, i, rec_m[i], rec_s[i], exp_q[i], i);
        end
      end
      n_cmp++;
      if (bus.o_STEP !== 3'd0) begin
        n_err++;
        $display("FAIL add_sub_len op=%h: step=%0d after 5 cycles, required 0", op, bus.o_STEP);
      end
    end
  endtask

  task automatic test_cond_jump();
    logic [OW-1:0] ops [4] = '{4'h7, 4'h7, 4'h8, 4'h8};
    logic          flg [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      build_seq(ops[k], flg[k], flg[k]);
      play(ops[k], flg[k], flg[k], exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (rec_m[i] !== exp_q[i] || rec_s[i] !== SW'(i)) begin
          n_err++;
          $display("FAIL cond_jump op=%h flag=%b T%0d: strobes=%h step=%0d, required %h/%0d", ops[k], flg[k], i, rec_m[i], rec_s[i], exp_q[i], i);
        end
      end
      n_cmp++;
      if (bus.o_STEP !== 3'd0) begin
        n_err++;
        $display("FAIL cond_jump_len op=%h: step=%0d, required 0", ops[k], bus.o_STEP);
      end
    end
  endtask

  task automatic test_halt();
    build_seq(4'hF, 1'b0, 1'b0);
    play(4'hF, 1'b0, 1'b0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (rec_m[i] !== exp_q[i] || rec_s[i] !== SW'(i) || rec_h[i] !== 1'b0) begin
        n_err++;
        $display("FAIL hlt T%0d: strobes=%h step=%0d halted=%b, required %h/%0d/0", i, rec_m[i], rec_s[i], rec_h[i], exp_q[i], i);
      end
    end
    for (int i = 0; i < 20; i++) begin
      bus.i_OPCODE = 4'($urandom);
      bus.i_CARRY  = 1'($urandom);
      bus.i_ZERO   = 1'($urandom);
      @(negedge clk);
      n_cmp++;
      if (obs() !== '0 || bus.o_STEP !== 3'd2 || bus.o_HALTED !== 1'b1) begin
        n_err++;
        $display("FAIL halted cycle %0d: strobes=%h step=%0d halted=%b, required 0000/2/1", i, obs(), bus.o_STEP, bus.o_HALTED);
      end
      @(posedge clk); #1;
    end
    clear_n = 1'b0;
    @(posedge clk); #1;
    clear_n = 1'b1;
    n_cmp++;
    if (bus.o_STEP !== 3'd0 || bus.o_HALTED !== 1'b0) begin
      n_err++;
      $display("FAIL halt_clear: step=%0d halted=%b, required 0/0", bus.o_STEP, bus.o_HALTED);
    end
    build_seq(4'h6, 1'b0, 1'b0);
    play(4'h6, 1'b0, 1'b0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (rec_m[i] !== exp_q[i] || rec_s[i] !== SW'(i)) begin
        n_err++;
        $display("FAIL resume T%0d: strobes=%h step=%0d, required %h/%0d", i, rec_m[i], rec_s[i], exp_q[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    build_seq(4'h2, 1'b0, 1'b0);
    play(4'h2, 1'b0, 1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rec_m[i] !== exp_q[i] || rec_s[i] !== SW'(i)) begin
        n_err++;
        $display("FAIL reset_mid pre T%0d: strobes=%h step=%0d, required %h/%0d", i, rec_m[i], rec_s[i], exp_q[i], i);
      end
    end
    clear_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (obs() !== '0) begin
      n_err++;
      $display("FAIL reset_mid T3: strobes=%h, required 0000", obs());
    end
    @(posedge clk); #1;
    clear_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs() !== FETCH0 || bus.o_STEP !== 3'd0) begin
      n_err++;
      $display("FAIL reset_mid restart: strobes=%h step=%0d, required %h/0", obs(), bus.o_STEP, FETCH0);
    end
    clear_n = 1'b0;
    @(posedge clk); #1;
    clear_n = 1'b1;
  endtask

  task automatic test_short();
    for (int k = 0; k < 2; k++) begin
      logic [OW-1:0] op;
      op = (k == 0) ? 4'h0 : 4'h9;
      build_seq(op, 1'b0, 1'b0);
      play(op, 1'($urandom), 1'($urandom), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (rec_m[i] !== exp_q[i] || rec_s[i] !== SW'(i)) begin
          n_err++;
          $display("FAIL short op=%h T%0d: strobes=%h step=%0d, required %h/%0d", op, i, rec_m[i], rec_s[i], exp_q[i], i);
        end
      end
      n_cmp++;
      if (bus.o_STEP !== 3'd0) begin
        n_err++;
        $display("FAIL short_len op=%h: step=%0d after 2 cycles, required 0", op, bus.o_STEP);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [OW-1:0] op;
      logic          c, z;
      op = 4'($urandom_range(0, 14));
      c  = 1'($urandom);
      z  = 1'($urandom);
      build_seq(op, c, z);
      play(op, c, z, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (rec_m[i] !== exp_q[i] || rec_s[i] !== SW'(i) || rec_h[i] !== 1'b0) begin
          n_err++;
          $display("FAIL random op=%h c=%b z=%b T%0d: strobes=%h step=%0d, required %h/%0d", op, c, z, i, rec_m[i], rec_s[i], exp_q[i], i);
        end
        n_cmp++;
        if ($countones(rec_m[i] & M_DRIVERS) > 1) begin
          n_err++;
          $display("FAIL bus_contention op=%h T%0d: drivers=%h, required at most one", op, i, rec_m[i] & M_DRIVERS);
        end
      end
    end
    n_cmp++;
    if (bus.o_STEP !== 3'd0) begin
      n_err++;
      $display("FAIL random_end: step=%0d, required 0", bus.o_STEP);
    end
  endtask

`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
  task automatic test_single_step();
    bus.i_STEP_MODE = 1'b1;
    bus.i_STEP      = 1'b0;
    bus.i_OPCODE    = 4'h1;
    build_seq(4'h1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== '0 || bus.o_STEP !== 3'd0) begin
        n_err++;
        $display("FAIL step_idle %0d: strobes=%h step=%0d, required 0000/0", i, obs(), bus.o_STEP);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      bus.i_STEP = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== exp_q[k] || bus.o_STEP !== SW'(k)) begin
        n_err++;
        $display("FAIL step_pulse %0d: strobes=%h step=%0d, required %h/%0d", k, obs(), bus.o_STEP, exp_q[k], k);
      end
      @(posedge clk); #1;
      bus.i_STEP = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs() !== '0 || bus.o_STEP !== SW'((k + 1) % 4)) begin
        n_err++;
        $display("FAIL step_gap %0d: strobes=%h step=%0d, required 0000/%0d", k, obs(), bus.o_STEP, (k + 1) % 4);
      end
      @(posedge clk); #1;
    end
    bus.i_STEP = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== ((j == 0) ? FETCH0 : '0) || bus.o_STEP !== ((j == 0) ? 3'd0 : 3'd1)) begin
        n_err++;
        $display("FAIL step_held %0d: strobes=%h step=%0d, required %h/%0d", j, obs(), bus.o_STEP, (j == 0) ? FETCH0 : '0, (j == 0) ? 0 : 1);
      end
      @(posedge clk); #1;
    end
    bus.i_STEP = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.o_STEP !== 3'd1) begin
      n_err++;
      $display("FAIL step_held_end: step=%0d, required 1", bus.o_STEP);
    end
    @(posedge clk); #1;
    bus.i_STEP_MODE = 1'b0;
    clear_n = 1'b0;
    @(posedge clk); #1;
    clear_n = 1'b1;
  endtask
`endif

  initial begin
    clear_n      = 1'b0;
    bus.i_OPCODE = '0;
    bus.i_CARRY  = 1'b0;
    bus.i_ZERO   = 1'b0;
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    bus.i_STEP_MODE = 1'b0;
    bus.i_STEP      = 1'b0;
`endif
    test_reset();
    test_ldi();
    test_add_sub();
    test_cond_jump();
    test_halt();
    test_reset_mid();
    test_short();
    test_random();
`ifdef CONTROL_SEQUENCER_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control sequencer for the 8-bit bus CPU. It drives the program counter's count/jump/output strobes and every other bus-attached unit's enables, one microstep per clock.
- Each instruction is a 2-step fetch (T0, T1) followed by a 0–3-step execute (T2–T4) selected by the opcode and the ALU flags.
- The block sits between the instruction register's opcode nibble / flags register and the shared bus, and is the only source of control strobes in the CPU.

Parameters:
- OPCODE_WIDTH, 4, width of i_OPCODE
- STEP_WIDTH, 3, width of the internal microstep counter and o_STEP (T0..T4 encoded as 0..4)

Ports:
- i_CLOCK  in  1  system clock; all state updates on rising edge
- i_CLEAR_n  in  1  reset, synchronous, active-low
- i_OPCODE  in  OPCODE_WIDTH  upper nibble of the instruction register
- i_CARRY  in  1  registered carry flag
- i_ZERO  in  1  registered zero flag
- o_PC_OUT  out  1  program counter drives bus
- o_PC_COUNT_ENABLE  out  1  program counter increments
- o_PC_JUMP  out  1  program counter loads from bus
- o_MAR_IN  out  1  memory address register loads
- o_RAM_OUT  out  1  RAM drives bus
- o_RAM_IN  out  1  RAM writes from bus
- o_IR_IN  out  1  instruction register loads
- o_IR_OUT  out  1  IR operand nibble drives bus
- o_A_IN  out  1  A register loads
- o_A_OUT  out  1  A drives bus
- o_B_IN  out  1  B register loads
- o_ALU_OUT  out  1  ALU drives bus
- o_ALU_SUB  out  1  ALU subtracts
- o_FLAGS_IN  out  1  flags register loads
- o_OUT_IN  out  1  output register loads
- o_HALTED  out  1  sequencer halted
- o_STEP  out  STEP_WIDTH  current microstep (debug)

Behaviour:
- State: step counter (0..4) plus halted flag.
- Reset:
  - i_CLEAR_n low at a rising edge → step=0, halted=0.
  - While i_CLEAR_n is low, all control outputs are forced to 0 combinationally.
  - o_STEP reads 0 from the first edge after reset is asserted.
- Control outputs are a combinational decode of (step, i_OPCODE, i_CARRY, i_ZERO). Each strobe is valid for the whole cycle and acted on by the target unit at the next rising edge (zero-cycle latency).
- Fetch:
  - T0: PC_OUT, MAR_IN.
  - T1: RAM_OUT, IR_IN, PC_COUNT_ENABLE.
- Execute (opcode hex):
  - 1 LDA: T2 IR_OUT+MAR_IN; T3 RAM_OUT+A_IN.
  - 2 ADD: T2 IR_OUT+MAR_IN; T3 RAM_OUT+B_IN; T4 ALU_OUT+A_IN+FLAGS_IN.
  - 3 SUB: as ADD, with ALU_SUB also asserted in T4.
  - 4 STA: T2 IR_OUT+MAR_IN; T3 A_OUT+RAM_IN.
  - 5 LDI: T2 IR_OUT+A_IN.
  - 6 JMP: T2 IR_OUT+PC_JUMP.
  - 7 JC: T2 IR_OUT+PC_JUMP only if i_CARRY=1; otherwise T2 asserts nothing.
  - 8 JZ: as JC, using i_ZERO.
  - E OUT: T2 A_OUT+OUT_IN.
  - F HLT: T2 asserts nothing; sets halted at end of T2.
  - 0 NOP, and all undefined opcodes: no execute steps.
- Variable length:
  - After the last defined step of an instruction, step returns to 0 on the next edge.
  - Instruction lengths: NOP 2; LDI/JMP/JC/JZ/OUT 3; LDA/STA 4; ADD/SUB 5.
  - A taken or untaken conditional jump is always 3 cycles.
- Step wrap: step never exceeds 4. A value above 4 (unreachable) returns to 0.
- Halted:
  - Step holds at 2 and all control outputs are 0; o_HALTED=1.
  - Only i_CLEAR_n low clears the halted state.
- Flags are sampled combinationally in T2 only. Changes in other steps have no effect.
- Reset mid-instruction: the next edge with i_CLEAR_n low aborts unconditionally and restarts at T0. No partial strobes are emitted during the reset cycle.
- Mutual exclusion: at most one bus driver (PC_OUT, RAM_OUT, IR_OUT, A_OUT, ALU_OUT) is high in any cycle.

Optional Feature:
- Macro: CONTROL_SEQUENCER_SINGLE_STEP_EN.
- When defined, two ports are added: i_STEP_MODE (1) and i_STEP (1).
  - A registered copy of i_STEP gives a rising-edge qualifier q = i_STEP & ~i_STEP_d.
  - With i_STEP_MODE=1: the step counter advances only in cycles with q=1, and all control outputs are ANDed with q. Each microstep therefore executes exactly once per i_STEP pulse.
  - With i_STEP_MODE=0: behaviour is identical to the macro being undefined.
  - i_STEP_d resets to 0.
- When undefined: the ports are absent, and the sequencer free-runs one step per clock.

Test Plan:
- Reset then opcode 5 (LDI) → T0 PC_OUT+MAR_IN; T1 RAM_OUT+IR_IN+PC_COUNT_ENABLE; T2 IR_OUT+A_IN; o_STEP back to 0 on cycle 4.
- Opcode 2 (ADD), then opcode 3 (SUB) → 5 cycles each; FLAGS_IN and ALU_OUT only at T4; ALU_SUB=1 only in SUB T4.
- Opcode 7 with i_CARRY=0, then i_CARRY=1; opcode 8 with i_ZERO=1 → PC_JUMP 0, then 1, then 1 at T2; every instruction 3 cycles.
- Opcode F → o_HALTED=1 from cycle 4; hold 20 cycles with all strobes 0 and o_STEP=2; i_CLEAR_n low one edge → o_STEP=0, o_HALTED=0, fetch resumes.
- ADD with i_CLEAR_n driven low during T3 → all strobes 0 that cycle; next cycle T0 PC_OUT+MAR_IN; opcode 0 and opcode 9 each take 2 cycles.
- With macro defined, i_STEP_MODE=1 and opcode 1 (LDA) → no strobes or step change without pulses; 4 single-cycle i_STEP pulses produce T0..T3 strobes, one per pulse; i_STEP held high 5 cycles counts as one pulse.
